// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit path.
// Line states are encoded as {d_plus, d_minus}.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP_SE0,
        EOP_J
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE    = 8'h80;
    localparam logic [2:0] MAX_ONES     = 3'd6;
    localparam int         EOP_SE0_BITS = 2;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    // A 0 toggles between J and K, a 1 holds; only valid while the line is J or K.
    function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic bit_val);
        return bit_val ? line : ~line;
    endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Free-running bit-time counter; bit_tick marks the last clk of each USB bit.
// Held at zero while clear is high so the first bit after a start is full length.
module usb_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear || (count == LAST_COUNT)) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign bit_tick = !clear && (count == LAST_COUNT);

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed packet transmitter: SYNC, LSB-first data with bit stuffing,
// NRZI line coding and EOP, driven straight onto registered D+/D-.
import usb_tx_pkg::*;

module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic       d_plus_out,
    output logic       d_minus_out
);

    localparam logic [1:0] EOP_LAST = 2'(EOP_SE0_BITS - 1);

    tx_state_t  state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [2:0] ones_cnt, ones_n;
    logic [7:0] data_reg, data_n;
    logic       last_flag, last_n;
    logic [1:0] eop_cnt, eop_n;
    logic [1:0] line, line_n;
    logic       busy, busy_n;
    logic       done, done_n;
    logic       err, err_n;

    logic       bit_tick;
    logic [2:0] bit_idx_next;
    logic       send_en;
    logic       send_bit;
    logic       data_step;

    usb_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (state == IDLE),
        .bit_tick(bit_tick)
    );

    assign bit_idx_next = bit_cnt + 3'd1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt   <= '0;
            ones_cnt  <= '0;
            data_reg  <= '0;
            last_flag <= 1'b0;
            eop_cnt   <= '0;
            line      <= LINE_J;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            bit_cnt   <= bit_cnt_n;
            ones_cnt  <= ones_n;
            data_reg  <= data_n;
            last_flag <= last_n;
            eop_cnt   <= eop_n;
            line      <= line_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

    // bit_cnt always indexes the bit currently on the line; every decision is
    // taken on bit_tick and lands on the line at the following edge.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        ones_n    = ones_cnt;
        data_n    = data_reg;
        last_n    = last_flag;
        eop_n     = eop_cnt;
        line_n    = line;
        busy_n    = busy;
        done_n    = 1'b0;
        err_n     = 1'b0;
        tx_ready  = 1'b0;
        send_en   = 1'b0;
        send_bit  = 1'b0;
        data_step = 1'b0;

        unique case (state)
            IDLE: begin
                tx_ready = tx_valid;
                if (tx_valid) begin
                    data_n    = tx_data;
                    last_n    = tx_last;
                    bit_cnt_n = '0;
                    eop_n     = '0;
                    busy_n    = 1'b1;
                    state_n   = SYNC;
                    send_en   = 1'b1;
                    send_bit  = SYNC_BYTE[0];
                end
            end
            SYNC: begin
                if (bit_tick) begin
                    send_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                        send_bit  = data_reg[0];
                    end else begin
                        bit_cnt_n = bit_idx_next;
                        send_bit  = SYNC_BYTE[bit_idx_next];
                    end
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (ones_cnt == MAX_ONES) begin
                        state_n = STUFF;
                        line_n  = ~line;
                        ones_n  = '0;
                    end else begin
                        data_step = 1'b1;
                    end
                end
            end
            STUFF: begin
                if (bit_tick) begin
                    state_n   = DATA;
                    data_step = 1'b1;
                end
            end
            EOP_SE0: begin
                if (bit_tick) begin
                    if (eop_cnt == EOP_LAST) begin
                        state_n = EOP_J;
                        line_n  = LINE_J;
                    end else begin
                        eop_n = eop_cnt + 2'd1;
                    end
                end
            end
            EOP_J: begin
                if (bit_tick) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Shared by DATA and the bit after a stuff bit: a pending stuff bit
        // therefore delays the byte-boundary handshake by one bit time.
        if (data_step) begin
            if (bit_cnt != 3'd7) begin
                bit_cnt_n = bit_idx_next;
                send_en   = 1'b1;
                send_bit  = data_reg[bit_idx_next];
            end else if (last_flag) begin
                state_n = EOP_SE0;
                line_n  = LINE_SE0;
                eop_n   = '0;
            end else if (tx_valid) begin
                tx_ready  = 1'b1;
                data_n    = tx_data;
                last_n    = tx_last;
                bit_cnt_n = '0;
                state_n   = DATA;
                send_en   = 1'b1;
                send_bit  = tx_data[0];
            end else begin
                err_n   = 1'b1;
                state_n = EOP_SE0;
                line_n  = LINE_SE0;
                eop_n   = '0;
            end
        end

        if (send_en) begin
            line_n = nrzi_next(line, send_bit);
            ones_n = send_bit ? (ones_cnt + 3'd1) : 3'd0;
        end
    end

    assign tx_busy     = busy;
    assign tx_done     = done;
    assign tx_err      = err;
    assign d_plus_out  = line[1];
    assign d_minus_out = line[0];

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Scoreboard bench for usb_tx_encoder: stimulus queues hand-derived line symbols
// and event timings, a negedge monitor pops and compares them as the DUT emits.
module tb_usb_tx_encoder;

    localparam int CPB = 8;

    logic       clk;
    logic       n_rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic       d_plus_out;
    logic       d_minus_out;

    int check_count = 0;
    int pass_count  = 0;
    int cyc         = 0;

    logic [1:0] exp_line[$];
    int         exp_done[$];
    int         exp_err[$];
    int         exp_gap[$];

    usb_tx_encoder #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .d_plus_out (d_plus_out),
        .d_minus_out(d_minus_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // J -> {1,0}, K -> {0,1}, 0 -> SE0
    task automatic pushExpected(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte c;
            c = s[i];
            if (c == "J")      exp_line.push_back(2'b10);
            else if (c == "K") exp_line.push_back(2'b01);
            else               exp_line.push_back(2'b00);
        end
    endtask

    // Inputs change 1 time unit after posedge; tx_ready is looked at on negedge.
    task automatic applyStimulus(input logic [7:0] first, input logic [7:0] second,
                                 input int n_bytes, input bit underrun);
        for (int i = 0; i < n_bytes; i++) begin
            bit got;
            @(posedge clk);
            #1;
            tx_valid = 1'b1;
            tx_data  = (i == 0) ? first : second;
            tx_last  = (i == n_bytes - 1) && !underrun;
            got = 1'b0;
            for (int k = 0; k < 400 && !got; k++) begin
                @(negedge clk);
                if (tx_ready) got = 1'b1;
            end
            if (!got) checkOutput("handshake_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic waitDrain();
        bit drained;
        drained = 1'b0;
        for (int k = 0; k < 600 && !drained; k++) begin
            @(negedge clk);
            if (!tx_busy && exp_line.size() == 0 && exp_done.size() == 0 && exp_err.size() == 0)
                drained = 1'b1;
        end
        checkOutput("packet_drained", int'(drained), 1);
        repeat (4) @(negedge clk);
    endtask

    // Monitor: bit phases are counted from the first busy cycle, sampled mid-bit.
    int phase    = 0;
    int bit_idx  = 0;
    int pkt_start = 0;
    int last_hs  = 0;
    bit prev_busy = 1'b0;

    always @(negedge clk) begin
        if (tx_valid && tx_ready) begin
            if (!tx_busy) begin
                pkt_start = cyc;
            end else if (exp_gap.size() > 0) begin
                checkOutput("byte_handshake_gap", cyc - last_hs, exp_gap.pop_front());
            end else begin
                checkOutput("ready_while_busy_expected", exp_gap.size(), 1);
            end
            last_hs = cyc;
        end
        if (tx_busy) begin
            if (!prev_busy) begin
                phase   = 0;
                bit_idx = 0;
                checkOutput("first_sync_bit_latency", int'({d_plus_out, d_minus_out}), 1);
            end else begin
                phase++;
            end
            if (phase % CPB == CPB / 2) begin
                if (exp_line.size() > 0)
                    checkOutput($sformatf("line_bit%0d", bit_idx),
                                int'({d_plus_out, d_minus_out}), int'(exp_line.pop_front()));
                else
                    checkOutput("line_extra_bit", exp_line.size(), 1);
                bit_idx++;
            end
        end
        if (tx_done) begin
            if (exp_done.size() > 0)
                checkOutput("done_cycle", cyc - pkt_start, exp_done.pop_front());
            else
                checkOutput("done_expected", exp_done.size(), 1);
            checkOutput("line_j_at_done", int'({d_plus_out, d_minus_out}), 2);
            checkOutput("bits_left_at_done", exp_line.size(), 0);
        end
        if (tx_err) begin
            if (exp_err.size() > 0)
                checkOutput("err_cycle", cyc - pkt_start, exp_err.pop_front());
            else
                checkOutput("err_expected", exp_err.size(), 1);
        end
        prev_busy = tx_busy;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int bad;
        n_rst    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("reset_dp", int'(d_plus_out), 1);
        checkOutput("reset_dm", int'(d_minus_out), 0);
        checkOutput("reset_busy", int'(tx_busy), 0);
        checkOutput("reset_done", int'(tx_done), 0);
        checkOutput("reset_err", int'(tx_err), 0);
        n_rst = 1'b1;

        $display("[TB] idle for 100 cycles");
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({d_plus_out, d_minus_out} != 2'b10 || tx_ready || tx_busy || tx_done || tx_err)
                bad++;
        end
        checkOutput("idle_quiet_cycles", bad, 0);

        $display("[TB] single byte 00");
        pushExpected("KJKJKJKKJKJKJKJK00J");
        exp_done.push_back(19 * CPB + 1);
        applyStimulus(8'h00, 8'h00, 1, 1'b0);
        waitDrain();

        $display("[TB] single byte FF with stuff bit");
        pushExpected("KJKJKJKKKKKKKJJJJ00J");
        exp_done.push_back(20 * CPB + 1);
        applyStimulus(8'hFF, 8'h00, 1, 1'b0);
        waitDrain();

        $display("[TB] two bytes A5 3C back to back");
        pushExpected("KJKJKJKKKJJKJJKKJKKKKKJK00J");
        exp_gap.push_back(16 * CPB);
        exp_done.push_back(27 * CPB + 1);
        applyStimulus(8'hA5, 8'h3C, 2, 1'b0);
        waitDrain();

        $display("[TB] underrun after 69");
        pushExpected("KJKJKJKKKJKKJJJK00J");
        exp_err.push_back(16 * CPB + 1);
        exp_done.push_back(19 * CPB + 1);
        applyStimulus(8'h69, 8'h00, 1, 1'b1);
        waitDrain();

        $display("[TB] reset during FF data");
        pushExpected("KJKJKJKKKKK");
        applyStimulus(8'hFF, 8'h00, 1, 1'b0);
        repeat (90) @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        checkOutput("midreset_line", int'({d_plus_out, d_minus_out}), 2);
        checkOutput("midreset_busy", int'(tx_busy), 0);
        repeat (3) @(negedge clk);
        checkOutput("midreset_bits_left", exp_line.size(), 0);
        n_rst = 1'b1;
        repeat (20) @(negedge clk);

        $display("[TB] fresh FF after reset");
        pushExpected("KJKJKJKKKKKKKJJJJ00J");
        exp_done.push_back(20 * CPB + 1);
        applyStimulus(8'hFF, 8'h00, 1, 1'b0);
        waitDrain();

        repeat (10) @(negedge clk);
        checkOutput("final_line_queue", exp_line.size(), 0);
        checkOutput("final_done_queue", exp_done.size(), 0);
        checkOutput("final_err_queue", exp_err.size(), 0);
        checkOutput("final_gap_queue", exp_gap.size(), 0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
